foo_change_fifo: RTL and testbench

//   Downstream consumer of the 4-bit initialised-register stage output (foo).

---
 rtl/foo_change_fifo.sv | 51 +++++
 tb/tb_foo_change_fifo.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/foo_change_fifo.sv
// foo_change_fifo: queues each change of the sampled foo bus into a small valid/ready FIFO
module foo_change_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [WIDTH-1:0]           last_value
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic change, pop, push;
    // change detection and handshake decode; a pop frees a slot for a same-cycle push
    always_comb begin
        change    = in_en && (in_data != last_value);
        out_valid = count != '0;
        pop       = out_valid && out_ready;
        push      = change && (count < CW'(DEPTH) || pop);
        out_data  = out_valid ? mem[rptr] : '0;
    end
    // reference, pointers, occupancy and sticky overflow; storage cleared so reads are never X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_value <= INIT;
            overflow   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (change) last_value <= in_data;
            if (change && !push) overflow <= 1'b1;
            if (push) begin
                mem[wptr] <= in_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_foo_change_fifo.sv
// tb_foo_change_fifo: queue-model scoreboard plus directed literal checks for foo_change_fifo
module tb_foo_change_fifo;
    localparam int DEPTH = 4;
    localparam logic [3:0] INIT = 4'd0;
    logic clk = 1'b0, rst, in_en, out_ready, out_valid, overflow;
    logic [3:0] in_data, out_data, last_value;
    logic [2:0] count;
    int pass_cnt = 0, total_cnt = 0;
    logic [3:0] q [$];
    logic [3:0] m_lv = INIT;
    logic m_ovf = 1'b0;
    bit ch, po, pu;

    foo_change_fifo #(.WIDTH(4), .DEPTH(DEPTH), .INIT(INIT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .overflow(overflow), .last_value(last_value)
    );

    always #5 clk = ~clk;

    // reference model: queue of changed values, sticky drop flag, last accepted sample
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_lv = INIT;
            m_ovf = 1'b0;
        end else begin
            ch = in_en && (in_data != m_lv);
            po = (q.size() != 0) && out_ready;
            pu = ch && ((q.size() < DEPTH) || po);
            if (po) void'(q.pop_front());
            if (pu) q.push_back(in_data);
            if (ch) m_lv = in_data;
            if (ch && !pu) m_ovf = 1'b1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    endtask

    // compare every cycle against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("m_data", 32'(out_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_last", 32'(last_value), 32'(m_lv));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_en = 1'b1; in_data = 4'd0; out_ready = 1'b0;
        #12 rst = 1'b0;
        // 1: constant input queues nothing
        repeat (10) step();
        chk("t1_count", 32'(count), 0);
        chk("t1_valid", 32'(out_valid), 0);
        chk("t1_ovf", 32'(overflow), 0);
        // 2: 0->3->3->5 queues 3,5
        in_data = 4'd3; step();
        step();
        in_data = 4'd5; step();
        chk("t2_count", 32'(count), 2);
        chk("t2_head0", 32'(out_data), 3);
        out_ready = 1'b1; step();
        chk("t2_head1", 32'(out_data), 5);
        step();
        chk("t2_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        // 3: five changes into four slots
        for (int i = 1; i <= 5; i++) begin
            in_data = 4'(i); step();
        end
        chk("t3_count", 32'(count), 4);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_last", 32'(last_value), 5);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", 32'(out_data), 32'(i));
            step();
        end
        chk("t3_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        // 4: full FIFO streaming through pointer wrap
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_data = 4'(i); step();
        end
        chk("t4_full", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 4'(i + 5); step();
        end
        chk("t4_count", 32'(count), 4);
        chk("t4_ovf", 32'(overflow), 0);
        chk("t4_head", 32'(out_data), 13);
        repeat (4) step();
        chk("t4_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        // 5: async reset mid-stream
        for (int i = 7; i <= 9; i++) begin
            in_data = 4'(i); step();
        end
        chk("t5_pre", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_data", 32'(out_data), 0);
        chk("t5_last", 32'(last_value), 32'(INIT));
        chk("t5_ovf", 32'(overflow), 0);
        in_en = 1'b0;
        #3 rst = 1'b0;
        // 6: disabled sampling freezes reference; re-enable yields one event
        in_data = 4'd0; step();
        in_data = 4'd9;
        repeat (3) step();
        chk("t6_count0", 32'(count), 0);
        chk("t6_last0", 32'(last_value), 0);
        in_en = 1'b1; step();
        chk("t6_count1", 32'(count), 1);
        chk("t6_data", 32'(out_data), 9);
        chk("t6_last1", 32'(last_value), 9);
        step();
        chk("t6_count2", 32'(count), 1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
